// File: rtl/vx_lsu_pkg.sv
// Shared types, constants and helpers for the LSU request dispatch stage.
package vx_lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, AMO} dispatch_state_e;

  localparam int unsigned INST_MOD_BITS   = 3;
  localparam int unsigned MAX_LANES       = 32;
  localparam int unsigned DEF_MAX_PENDING = 16;
  localparam int unsigned PENDING_CNT_W   = $clog2(DEF_MAX_PENDING + 1);

  function automatic logic [5:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [MAX_LANES-1:0] lowest_one_hot(input logic [MAX_LANES-1:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/vx_lsu_req_dispatch_if.sv
// LSU-side request and dcache-side request bus seen by the dispatch stage.
interface vx_lsu_req_dispatch_if #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned TAG_WIDTH = 8
) ();
  import vx_lsu_pkg::*;

  localparam int unsigned WORD_WIDTH      = 8 * WORD_SIZE;
  localparam int unsigned WORD_ADDR_WIDTH = 32 - $clog2(WORD_SIZE);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_REQS-1:0]                  in_mask;
  logic                                 in_rw;
  logic [INST_MOD_BITS-1:0]             in_op_mod;
  logic                                 in_is_amo;
  logic [NUM_REQS*WORD_SIZE-1:0]        in_byteen;
  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]  in_addr;
  logic [NUM_REQS*WORD_WIDTH-1:0]       in_data;
  logic [TAG_WIDTH-1:0]                 in_tag;

  logic [NUM_REQS-1:0]                  dcache_req_valid;
  logic [NUM_REQS-1:0]                  dcache_req_rw;
  logic [NUM_REQS*INST_MOD_BITS-1:0]    dcache_req_op_mod;
  logic [NUM_REQS-1:0]                  dcache_req_is_amo;
  logic [NUM_REQS*WORD_SIZE-1:0]        dcache_req_byteen;
  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0]  dcache_req_addr;
  logic [NUM_REQS*WORD_WIDTH-1:0]       dcache_req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]        dcache_req_tag;
  logic [NUM_REQS-1:0]                  dcache_req_ready;
  logic [NUM_REQS-1:0]                  dcache_rsp_fire;

  modport master (
    input  in_valid, in_mask, in_rw, in_op_mod, in_is_amo, in_byteen, in_addr, in_data, in_tag,
    output in_ready,
    output dcache_req_valid, dcache_req_rw, dcache_req_op_mod, dcache_req_is_amo,
           dcache_req_byteen, dcache_req_addr, dcache_req_data, dcache_req_tag,
    input  dcache_req_ready, dcache_rsp_fire
  );

  modport slave (
    output in_valid, in_mask, in_rw, in_op_mod, in_is_amo, in_byteen, in_addr, in_data, in_tag,
    input  in_ready,
    input  dcache_req_valid, dcache_req_rw, dcache_req_op_mod, dcache_req_is_amo,
           dcache_req_byteen, dcache_req_addr, dcache_req_data, dcache_req_tag,
    output dcache_req_ready, dcache_rsp_fire
  );

endinterface

// File: rtl/vx_pending_counter.sv
// Saturating up/down counter of outstanding lanes with a "next step would overflow" flag.
module vx_pending_counter #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned MAX   = 16,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inc,
  input  logic [WIDTH-1:0] dec,
  output logic [WIDTH-1:0] cnt,
  output logic             near_full
);

  localparam logic [WIDTH:0] MaxV  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] StepV = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum, diff;

  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, inc};
    diff  = '0;
    cnt_d = cnt_q;
    // Responses without a matching outstanding lane clamp at zero.
    if ({1'b0, dec} >= sum) begin
      cnt_d = '0;
    end else begin
      diff  = sum - {1'b0, dec};
      cnt_d = (diff > MaxV) ? MaxV[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign near_full = ({1'b0, cnt_q} + StepV) > MaxV;

endmodule

// File: rtl/vx_lsu_req_dispatch.sv
// Holds one warp-wide LSU request and issues its lanes to the dcache until all have fired.
module vx_lsu_req_dispatch
  import vx_lsu_pkg::*;
#(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned WORD_SIZE   = 4,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_lsu_req_dispatch_if.master bus,
  output logic                  busy
);

  localparam int unsigned WORD_WIDTH      = 8 * WORD_SIZE;
  localparam int unsigned WORD_ADDR_WIDTH = 32 - $clog2(WORD_SIZE);
  localparam int unsigned CNT_W           = $clog2(MAX_PENDING + 1);

  dispatch_state_e state_q, state_d;
  logic [NUM_REQS-1:0] rem_mask_q, rem_mask_d;

  logic                                rw_q;
  logic [INST_MOD_BITS-1:0]            op_mod_q;
  logic                                is_amo_q;
  logic [NUM_REQS*WORD_SIZE-1:0]       byteen_q;
  logic [NUM_REQS*WORD_ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQS*WORD_WIDTH-1:0]      data_q;
  logic [TAG_WIDTH-1:0]                tag_q;

  logic [CNT_W-1:0]    pending_cnt, inc_amt, dec_amt;
  logic                near_full, counted, gate;
  logic [NUM_REQS-1:0] req_valid, fire;
  logic                last, in_ready, accept, load;

  always_comb begin
    counted   = !rw_q || is_amo_q;
    gate      = counted && near_full;
    req_valid = '0;
    unique case (state_q)
      ISSUE:   if (!gate) req_valid = rem_mask_q;
      AMO:     if (!gate) req_valid = NUM_REQS'(lowest_one_hot(MAX_LANES'(rem_mask_q)));
      default: req_valid = '0;
    endcase

    fire     = req_valid & bus.dcache_req_ready;
    last     = (state_q != IDLE) && (fire == rem_mask_q);
    in_ready = (state_q == IDLE) || last;
    accept   = bus.in_valid && in_ready;
    // An empty-mask request is consumed without ever reaching the dcache.
    load     = accept && (bus.in_mask != '0);

    state_d    = state_q;
    rem_mask_d = rem_mask_q & ~fire;
    if (load) begin
      state_d    = bus.in_is_amo ? AMO : ISSUE;
      rem_mask_d = bus.in_mask;
    end else if (last) begin
      state_d    = IDLE;
      rem_mask_d = '0;
    end

    inc_amt = counted ? CNT_W'(popcount(MAX_LANES'(fire))) : '0;
    dec_amt = CNT_W'(popcount(MAX_LANES'(bus.dcache_rsp_fire)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rw_q     <= bus.in_rw;
      op_mod_q <= bus.in_op_mod;
      is_amo_q <= bus.in_is_amo;
      byteen_q <= bus.in_byteen;
      addr_q   <= bus.in_addr;
      data_q   <= bus.in_data;
      tag_q    <= bus.in_tag;
    end
  end

  vx_pending_counter #(
    .WIDTH (CNT_W),
    .MAX   (MAX_PENDING),
    .STEP  (NUM_REQS)
  ) u_pending (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc_amt),
    .dec       (dec_amt),
    .cnt       (pending_cnt),
    .near_full (near_full)
  );

  assign bus.in_ready          = in_ready;
  assign bus.dcache_req_valid  = req_valid;
  assign bus.dcache_req_rw     = {NUM_REQS{rw_q}};
  assign bus.dcache_req_op_mod = {NUM_REQS{op_mod_q}};
  assign bus.dcache_req_is_amo = {NUM_REQS{is_amo_q}};
  assign bus.dcache_req_byteen = byteen_q;
  assign bus.dcache_req_addr   = addr_q;
  assign bus.dcache_req_data   = data_q;
  assign bus.dcache_req_tag    = {NUM_REQS{tag_q}};

  assign busy = (state_q != IDLE) || (pending_cnt != '0);

endmodule
